fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, 16, idle cycles before a partial word is auto-emitted (0 disables auto-emit).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  upstream byte FIFO empty flag.
- fifo_rd_en  out  1  pop request to the upstream FIFO.
- fifo_dout  in  8  upstream FIFO read data.
- flush  in  1  single-cycle request to emit the current partial word.
- word_valid  out  1  output word available.
- word_ready  in  1  downstream accepts the word.
- word_data  out  32  packed word.
- word_be  out  4  byte-lane enables for word_data.

Function
REQ-003 The upstream FIFO read latency SHALL be 1: when fifo_rd_en is high at edge N, the block captures fifo_dout at edge N+1; an internal pend flag tracks the in-flight byte.
REQ-004 fifo_rd_en SHALL be combinational: high only when state=FILL, fifo_empty=0, cnt+pend<4, and no emit is pending.
REQ-005 fifo_rd_en SHALL never be high while fifo_empty=1, in EMIT, or while rst_n=0.
REQ-006 A captured byte with lane count cnt=k SHALL be written to word_data[8k+7:8k]; word_be[k] is set and cnt increments; the first byte goes to lane 0 (little-endian).
REQ-007 Lanes not yet written SHALL read 0 in word_data and 0 in word_be.
REQ-008 The FSM SHALL have two states: FILL and EMIT.
- FILL -> EMIT when cnt reaches 4 (word_be=4'hF).
- FILL -> EMIT on a flush request or timeout with cnt>0 and pend=0.
- EMIT -> FILL on the edge where word_valid and word_ready are both 1; on that edge cnt, word_data and word_be clear to 0.
REQ-009 word_valid SHALL be 1 exactly while state=EMIT.
REQ-010 word_data and word_be SHALL be stable from word_valid rise until handshake (no change under backpressure).
REQ-011 flush SHALL be latched into a sticky flush_req and cleared on entry to EMIT.
REQ-012 If pend=1 when flush arrives, the block SHALL issue no new reads and SHALL emit on the edge after the in-flight byte lands.
REQ-013 flush with cnt=0 and pend=0 SHALL be ignored and SHALL not set flush_req.
REQ-014 flush asserted while in EMIT SHALL be ignored.
REQ-015 The idle timer SHALL clear to 0 on every byte capture.
REQ-016 In FILL with cnt>0, pend=0 and no capture, the idle timer SHALL increment each edge; reaching TIMEOUT forces FILL -> EMIT.
REQ-017 word_valid SHALL rise TIMEOUT+1 edges after the capture edge of the last byte.
REQ-018 The idle timer SHALL saturate and SHALL not count when cnt=0.
REQ-019 If cnt reaches 4 on the same edge as a flush or timeout, the block SHALL emit a single full word (be=4'hF) and clear flush_req.
REQ-020 Bytes SHALL never be dropped or duplicated: the number of rd_en pulses SHALL equal the total number of set be bits emitted, excluding data lost at reset.

Reset
REQ-021 While rst_n=0, the block SHALL asynchronously force: word_valid=0, word_data=0, word_be=0, fifo_rd_en=0, state=FILL, cnt=0, pend=0, flush_req=0, timer=0.
REQ-022 Reset mid-operation SHALL discard any partial word and in-flight byte; after release, packing restarts at lane 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- FIFO holds 0x11,0x22,0x33,0x44, word_ready=1 -> exactly 4 fifo_rd_en pulses; word_data=0x44332211, word_be=4'hF; word_valid high 1 cycle.
- Full word pending, word_ready=0 for 10 cycles -> word_valid stays 1, word_data/word_be stable, fifo_rd_en stays 0; handshake on cycle 11, then reads resume.
- Bytes 0xAA,0xBB then one-cycle flush -> word_data=0x0000BBAA, word_be=4'b0011.
- Single byte 0x5A, no flush, TIMEOUT=16 -> word_valid rises 17 edges after capture; word_be=4'b0001, word_data=0x0000005A.
- fifo_empty=1 throughout, flush pulsed -> fifo_rd_en never 1, word_valid never 1.
- rst_n driven low during EMIT -> word_valid=0 immediately without a clock edge; after release, bytes 0x01..0x04 -> word_data=0x04030201.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Packs bytes from an upstream 1-cycle-latency FIFO into 32-bit little-endian words.
// A partial word is emitted on flush or after TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic        flush,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [3:0]  word_be
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic          r_pend;
  logic          r_flush_req;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_data;
  logic [3:0]    r_be;

  logic [2:0]    w_fill_lvl;
  logic          w_flush_hit;
  logic          w_timeout;
  logic          w_emit_req;
  logic          w_rd_en;

  // Lanes committed plus the byte still in flight from the FIFO.
  assign w_fill_lvl  = r_cnt + 3'(r_pend);
  assign w_flush_hit = (r_state == FILL) && (r_flush_req || (flush && (w_fill_lvl != 3'd0)));
  assign w_timeout   = (TIMEOUT != 0) && (r_state == FILL) && (r_cnt != 3'd0) && (r_timer == TMAX);
  assign w_emit_req  = w_flush_hit || w_timeout;
  assign w_rd_en     = rst_n && (r_state == FILL) && !fifo_empty &&
                       (w_fill_lvl < 3'd4) && !w_emit_req;

  assign fifo_rd_en  = w_rd_en;
  assign word_valid  = (r_state == EMIT);
  assign word_data   = r_data;
  assign word_be     = r_be;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: full word, or a requested/timed-out emit once nothing is in flight.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL: begin
        if ((w_fill_lvl == 3'd4) || (w_emit_req && !r_pend && (r_cnt != 3'd0))) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (word_ready) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Datapath: byte capture, flush latch and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 3'd0;
      r_pend      <= 1'b0;
      r_flush_req <= 1'b0;
      r_timer     <= '0;
      r_data      <= 32'd0;
      r_be        <= 4'd0;
    end else begin
      r_pend      <= w_rd_en;
      r_flush_req <= (w_state_nxt == FILL) && w_flush_hit;
      if (r_state == EMIT) begin
        if (word_ready) begin
          r_cnt   <= 3'd0;
          r_timer <= '0;
          r_data  <= 32'd0;
          r_be    <= 4'd0;
        end
      end else if (r_pend) begin
        r_data[{r_cnt[1:0], 3'b000} +: 8] <= fifo_dout;
        r_be[r_cnt[1:0]]                  <= 1'b1;
        r_cnt                             <= r_cnt + 3'd1;
        r_timer                           <= '0;
      end else if ((r_cnt != 3'd0) && (r_timer != TMAX)) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized checks of fifo_word_packer against a byte-stream model
// of the upstream FIFO and the expected packed output.
module tb_fifo_word_packer;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'd0;
  logic        flush = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic [3:0]  word_be;

  fifo_word_packer #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_be    (word_be)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: 1-cycle read latency.
  logic [7:0] mem [0:1023];
  logic [9:0] wr_ptr = 10'd0;
  logic [9:0] rd_ptr = 10'd0;
  int         cyc = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= 10'(rd_ptr + 10'd1);
    end
  end

  // Output monitor.
  logic [35:0] obs_q[$];
  int          rd_total = 0;
  int          be_total = 0;
  int          bad_rd = 0;
  int          stab_err = 0;
  int          valid_cyc = 0;
  int          last_rd_edge = 0;
  int          rise_edge = 0;
  logic        held = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_data = 32'd0;
  logic [3:0]  held_be = 4'd0;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_total++;
      last_rd_edge = cyc + 1;
      if (fifo_empty) bad_rd++;
    end
    if (word_valid) valid_cyc++;
    if (rst_n && held && (!word_valid || word_data != held_data || word_be != held_be)) stab_err++;
    held      = rst_n && word_valid && !word_ready;
    held_data = word_data;
    held_be   = word_be;
    if (word_valid && !prev_valid) rise_edge = cyc;
    prev_valid = word_valid;
    if (word_valid && word_ready) begin
      obs_q.push_back({word_be, word_data});
      be_total += $countones(word_be);
    end
  end

  int checks = 0;
  int errors = 0;
  int obs_rd = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = 10'(wr_ptr + 10'd1);
  endtask

  task automatic get_word(output logic [35:0] w, input int budget, input string tag);
    int n = 0;
    while (obs_rd >= obs_q.size() && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    assert (obs_rd < obs_q.size()) else begin
      errors++;
      $error("FAIL %s_wait: observed no word expected a word within %0d cycles", tag, budget);
    end
    if (obs_rd < obs_q.size()) begin
      w = obs_q[obs_rd];
      obs_rd++;
    end else begin
      w = '0;
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!word_valid && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_valid_rise"}, 36'(word_valid), 36'(1));
  endtask

  initial begin
    logic [35:0] w;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          rd0, v0, st0, be0, start, lost, n;
    logic [7:0]  b;
    logic [3:0]  be;
    logic [31:0] d, mask;
    logic        ok;

    lost = 0;
    #2 rst_n = 1'b0;
    tick(2);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk("rst_valid", 36'(word_valid), 36'(0));
    chk("rst_data", 36'(word_data), 36'(0));
    chk("rst_be", 36'(word_be), 36'(0));
    chk("rst_rd_en", 36'(fifo_rd_en), 36'(0));

    // Full word with ready high.
    word_ready = 1'b1;
    rd0 = rd_total; v0 = valid_cyc;
    tick(1);
    rst_n = 1'b1;
    get_word(w, 40, "full");
    tick(3);
    chk("full_data", 36'(w[31:0]), 36'(32'h44332211));
    chk("full_be", 36'(w[35:32]), 36'(4'hF));
    chk("full_rd_pulses", 36'(rd_total - rd0), 36'(4));
    chk("full_valid_cycles", 36'(valid_cyc - v0), 36'(1));

    // Backpressure for 10 cycles, then a fifth byte follows.
    word_ready = 1'b0;
    rd0 = rd_total; st0 = stab_err;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hB5);
    wait_valid(40, "bp");
    v0 = rd_total;
    tick(10);
    chk("bp_valid_held", 36'(word_valid), 36'(1));
    chk("bp_be_held", 36'(word_be), 36'(4'hF));
    chk("bp_no_reads", 36'(rd_total - v0), 36'(0));
    chk("bp_stable", 36'(stab_err - st0), 36'(0));
    word_ready = 1'b1;
    get_word(w, 5, "bp");
    chk("bp_data", 36'(w[31:0]), 36'(32'hA4A3A2A1));
    get_word(w, 60, "bp_tail");
    chk("bp_tail_data", 36'(w[31:0]), 36'(32'h000000B5));
    chk("bp_tail_be", 36'(w[35:32]), 36'(4'h1));
    chk("bp_rd_pulses", 36'(rd_total - rd0), 36'(5));

    // Two bytes then flush.
    tick(2);
    push(8'hAA); push(8'hBB);
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    get_word(w, 10, "flush");
    chk("flush_data", 36'(w[31:0]), 36'(32'h0000BBAA));
    chk("flush_be", 36'(w[35:32]), 36'(4'h3));

    // Single byte, timeout emit.
    tick(2);
    push(8'h5A);
    get_word(w, 60, "tmo");
    tick(2);
    chk("tmo_data", 36'(w[31:0]), 36'(32'h0000005A));
    chk("tmo_be", 36'(w[35:32]), 36'(4'h1));
    chk("tmo_latency", 36'(rise_edge - last_rd_edge), 36'(TIMEOUT + 2));

    // Empty FIFO with flush does nothing.
    rd0 = rd_total; v0 = valid_cyc;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(30);
    chk("empty_no_reads", 36'(rd_total - rd0), 36'(0));
    chk("empty_no_valid", 36'(valid_cyc - v0), 36'(0));

    // Reset while a word is held in EMIT.
    word_ready = 1'b0;
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    wait_valid(40, "rst_mid");
    tick(2);
    rst_n = 1'b0;
    lost += 4;
    #1;
    chk("rst_mid_valid", 36'(word_valid), 36'(0));
    chk("rst_mid_be", 36'(word_be), 36'(0));
    chk("rst_mid_data", 36'(word_data), 36'(0));
    chk("rst_mid_rd_en", 36'(fifo_rd_en), 36'(0));
    tick(2);
    rst_n = 1'b1;
    word_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    get_word(w, 40, "post_rst");
    chk("post_rst_data", 36'(w[31:0]), 36'(32'h04030201));
    chk("post_rst_be", 36'(w[35:32]), 36'(4'hF));

    // Randomized traffic, checked as a byte stream.
    tick(3);
    start = obs_q.size();
    obs_rd = start;
    be0 = be_total;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        push(b);
        exp_q.push_back(b);
      end
      word_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    flush = 1'b0;
    word_ready = 1'b1;
    n = 0;
    while ((be_total - be0) < exp_q.size() && n < 600) begin
      tick(1);
      n++;
    end
    tick(3);
    for (int i = start; i < obs_q.size(); i++) begin
      be = obs_q[i][35:32];
      d  = obs_q[i][31:0];
      ok = (be == 4'h1) || (be == 4'h3) || (be == 4'h7) || (be == 4'hF);
      chk("rand_be_shape", 36'(ok), 36'(1));
      mask = 32'd0;
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mask[8*l +: 8] = 8'hFF;
          got_q.push_back(d[8*l +: 8]);
        end
      end
      chk("rand_unused_lanes", 36'(d & ~mask), 36'(0));
    end
    obs_rd = obs_q.size();
    chk("rand_len", 36'(got_q.size()), 36'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("rand_byte", 36'(got_q[i]), 36'(exp_q[i]));
    end

    chk("rd_vs_be_total", 36'(rd_total - be_total), 36'(lost));
    chk("no_rd_when_empty", 36'(bad_rd), 36'(0));
    chk("stable_under_bp", 36'(stab_err), 36'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
